// File: rtl/bundle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bundle_pkg
// Description : Shared constants and helpers for the bundling counter.
// Revision    : 1.0 - initial release
// ============================================================================
package bundle_pkg;

    localparam int C_W_MIN     = 4;
    localparam int C_W_MAX     = 32;
    localparam int C_NCORE_MIN = 1;
    localparam int C_NCORE_MAX = 64;
    localparam int C_CH_W      = 2;

    function automatic int tree_levels(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int tree_width(input int n);
        return tree_levels(n) + 2;
    endfunction

    function automatic int tree_leaves(input int n);
        return 1 << tree_levels(n);
    endfunction

    // Nodes are stored level by level; level lvl (>=1) starts at this index.
    function automatic int level_offset(input int leaves, input int lvl);
        return leaves - (leaves >> (lvl - 1));
    endfunction

    function automatic logic [C_CH_W-1:0] map_channel(input logic st, input logic cr);
        if (!st) begin
            return 2'b00;
        end
        return cr ? 2'b11 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bundle_adder_tree.sv
`default_nettype none
// ============================================================================
// Module      : bundle_adder_tree
// Description : Registered binary reduction of NCORE signed values with valids.
// Revision    : 1.0 - initial release
// ============================================================================
module bundle_adder_tree
    import bundle_pkg::*;
#(
    parameter int NCORE = 32,
    parameter int IW    = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_flush,
    input  logic                               i_valid,
    input  logic [NCORE*IW-1:0]                i_data,
    output logic signed [tree_width(NCORE)-1:0] o_sum,
    output logic                               o_valid,
    output logic                               o_busy
);

    localparam int C_SW = tree_width(NCORE);
    localparam int C_L  = tree_levels(NCORE);
    localparam int C_P  = tree_leaves(NCORE);
    localparam int C_NN = C_P - 1;

    if (IW > C_SW) begin : g_chk_iw
        $error("bundle_adder_tree: IW wider than tree level width");
    end

    if (C_L == 0) begin : g_direct
        assign o_sum   = C_SW'(signed'(i_data[IW-1:0]));
        assign o_valid = i_valid;
        assign o_busy  = 1'b0;
    end else begin : g_levels
        logic [C_P*C_SW-1:0]  leaf;
        logic [C_NN*C_SW-1:0] node_d;
        logic [C_NN*C_SW-1:0] node_q;
        logic [C_L:1]         vld_d;
        logic [C_L:1]         vld_q;
        logic signed [C_SW-1:0] op_a;
        logic signed [C_SW-1:0] op_b;

        // Padding leaves beyond NCORE stay zero so they never disturb the sum.
        always_comb begin
            leaf   = '0;
            node_d = '0;
            op_a   = '0;
            op_b   = '0;
            for (int k = 0; k < NCORE; k++) begin
                leaf[k*C_SW +: C_SW] = C_SW'(signed'(i_data[k*IW +: IW]));
            end
            for (int i = 1; i <= C_L; i++) begin
                for (int j = 0; j < (C_P >> i); j++) begin
                    if (i == 1) begin
                        op_a = leaf[(2*j)*C_SW +: C_SW];
                        op_b = leaf[(2*j+1)*C_SW +: C_SW];
                    end else begin
                        op_a = node_q[(level_offset(C_P, i-1) + 2*j)*C_SW +: C_SW];
                        op_b = node_q[(level_offset(C_P, i-1) + 2*j + 1)*C_SW +: C_SW];
                    end
                    node_d[(level_offset(C_P, i) + j)*C_SW +: C_SW] = op_a + op_b;
                end
            end
        end

        always_comb begin
            vld_d    = '0;
            vld_d[1] = i_valid & ~i_flush;
            for (int i = 2; i <= C_L; i++) begin
                vld_d[i] = vld_q[i-1] & ~i_flush;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                node_q <= '0;
                vld_q  <= '0;
            end else begin
                node_q <= node_d;
                vld_q  <= vld_d;
            end
        end

        assign o_sum   = node_q[(C_NN-1)*C_SW +: C_SW];
        assign o_valid = vld_q[C_L];
        assign o_busy  = |vld_q;
    end

endmodule
`default_nettype wire

// File: rtl/bundle_counter.sv
`default_nettype none
// ============================================================================
// Module      : bundle_counter
// Description : Pipelined signed bundling accumulator over NCORE result bits.
// Revision    : 1.0 - initial release
// ============================================================================
module bundle_counter
    import bundle_pkg::*;
#(
    parameter int W        = 30,
    parameter int NCORE    = 32,
    parameter int SATURATE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                tmp_even,
    input  logic                tmp_rand_bit,
    input  logic [NCORE-1:0]    store,
    input  logic [NCORE-1:0]    core_result,
    output logic signed [W-1:0] count,
    output logic                sign_bit,
    output logic                sat_flag,
    output logic                busy
);

    localparam int C_SW = tree_width(NCORE);
    // Accumulate one bit wider than the larger operand so overflow is visible.
    localparam int C_AW = ((W > C_SW) ? W : C_SW) + 1;
    localparam logic signed [C_AW-1:0] C_MAX = C_AW'((longint'(1) << (W - 1)) - 1);
    localparam logic signed [C_AW-1:0] C_MIN = C_AW'(-(longint'(1) << (W - 1)));
    localparam logic signed [W-1:0]    C_PLUS_ONE  = W'(1);
    localparam logic signed [W-1:0]    C_MINUS_ONE = '1;

    if (W < C_W_MIN || W > C_W_MAX) begin : g_chk_w
        $error("bundle_counter: W out of range");
    end
    if (NCORE < C_NCORE_MIN || NCORE > C_NCORE_MAX) begin : g_chk_ncore
        $error("bundle_counter: NCORE out of range");
    end
    if (SATURATE != 0 && SATURATE != 1) begin : g_chk_sat
        $error("bundle_counter: SATURATE must be 0 or 1");
    end

    logic [C_CH_W*NCORE-1:0] ch_d;
    logic [C_CH_W*NCORE-1:0] ch_q;
    logic                    s0_vld_d;
    logic                    s0_vld_q;
    logic signed [C_SW-1:0]  tree_sum;
    logic                    tree_vld;
    logic                    tree_busy;
    logic signed [C_AW-1:0]  acc_sum;
    logic                    ovf_hi;
    logic                    ovf_lo;
    logic signed [W-1:0]     count_d;
    logic signed [W-1:0]     count_q;
    logic                    sat_d;
    logic                    sat_q;

    // Stage S0: a store coinciding with clear is dropped here.
    always_comb begin
        ch_d = '0;
        for (int k = 0; k < NCORE; k++) begin
            ch_d[C_CH_W*k +: C_CH_W] = map_channel(store[k], core_result[k]);
        end
        s0_vld_d = |store;
        if (clear) begin
            ch_d     = '0;
            s0_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q     <= '0;
            s0_vld_q <= 1'b0;
        end else begin
            ch_q     <= ch_d;
            s0_vld_q <= s0_vld_d;
        end
    end

    bundle_adder_tree #(
        .NCORE (NCORE),
        .IW    (C_CH_W)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .i_flush (clear),
        .i_valid (s0_vld_q),
        .i_data  (ch_q),
        .o_sum   (tree_sum),
        .o_valid (tree_vld),
        .o_busy  (tree_busy)
    );

    always_comb begin
        acc_sum = C_AW'(count_q) + C_AW'(tree_sum);
        ovf_hi  = 1'b0;
        ovf_lo  = 1'b0;
        count_d = count_q;
        sat_d   = sat_q;
        if (clear) begin
            sat_d = 1'b0;
            if (!tmp_even) begin
                count_d = '0;
            end else if (tmp_rand_bit) begin
                count_d = C_MINUS_ONE;
            end else begin
                count_d = C_PLUS_ONE;
            end
        end else if (tree_vld) begin
            ovf_hi  = (acc_sum > C_MAX);
            ovf_lo  = (acc_sum < C_MIN);
            count_d = acc_sum[W-1:0];
            if (SATURATE == 1 && ovf_hi) begin
                count_d = W'(C_MAX);
            end else if (SATURATE == 1 && ovf_lo) begin
                count_d = W'(C_MIN);
            end
            sat_d = sat_q | ovf_hi | ovf_lo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count    = count_q;
    assign sign_bit = count_q[W-1];
    assign sat_flag = sat_q;
    assign busy     = s0_vld_q | tree_busy;

endmodule
`default_nettype wire

// File: tb/tb_bundle_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bundle_counter
// Description : Self-checking bench for bundle_counter in four configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bundle_counter;

    localparam int C_LA = 2;   // tree levels for NCORE=4
    localparam int C_LB = 5;   // tree levels for NCORE=32

    typedef struct {
        longint due;
        longint val;
    } pend_t;

    typedef struct {
        bit       clr;
        bit       te;
        bit       tr;
        bit [3:0] st;
        bit [3:0] cr;
        int       cnt;
        bit       busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        clr_a = 1'b0, te_a = 1'b0, tr_a = 1'b0;
    logic [3:0]  st_a = '0, cr_a = '0;
    logic signed [29:0] cnt_a;
    logic        sign_a, sat_a, busy_a;

    logic        clr_b = 1'b0, te_b = 1'b0, tr_b = 1'b0;
    logic [31:0] st_b = '0, cr_b = '0;
    logic signed [29:0] cnt_b;
    logic        sign_b, sat_b, busy_b;

    logic        clr_cd = 1'b0, te_cd = 1'b0, tr_cd = 1'b0;
    logic [3:0]  st_cd = '0, cr_cd = '0;
    logic signed [3:0] cnt_c, cnt_d;
    logic        sign_c, sat_c, busy_c, sign_d, sat_d, busy_d;

    bundle_counter #(.W(30), .NCORE(4), .SATURATE(1)) u_a (
        .clk(clk), .rst(rst), .clear(clr_a), .tmp_even(te_a), .tmp_rand_bit(tr_a),
        .store(st_a), .core_result(cr_a), .count(cnt_a), .sign_bit(sign_a),
        .sat_flag(sat_a), .busy(busy_a));

    bundle_counter #(.W(30), .NCORE(32), .SATURATE(1)) u_b (
        .clk(clk), .rst(rst), .clear(clr_b), .tmp_even(te_b), .tmp_rand_bit(tr_b),
        .store(st_b), .core_result(cr_b), .count(cnt_b), .sign_bit(sign_b),
        .sat_flag(sat_b), .busy(busy_b));

    bundle_counter #(.W(4), .NCORE(4), .SATURATE(1)) u_c (
        .clk(clk), .rst(rst), .clear(clr_cd), .tmp_even(te_cd), .tmp_rand_bit(tr_cd),
        .store(st_cd), .core_result(cr_cd), .count(cnt_c), .sign_bit(sign_c),
        .sat_flag(sat_c), .busy(busy_c));

    bundle_counter #(.W(4), .NCORE(4), .SATURATE(0)) u_d (
        .clk(clk), .rst(rst), .clear(clr_cd), .tmp_even(te_cd), .tmp_rand_bit(tr_cd),
        .store(st_cd), .core_result(cr_cd), .count(cnt_d), .sign_bit(sign_d),
        .sat_flag(sat_d), .busy(busy_d));

    int     n_chk  = 0;
    int     n_pass = 0;
    longint cyc    = 0;
    longint ma_cnt = 0, mb_cnt = 0;
    bit     ma_sat = 1'b0, mb_sat = 1'b0;
    pend_t  qa[$];
    pend_t  qb[$];
    vec_t   tbl[18];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint init_val(input bit te, input bit tr);
        return te ? (tr ? -1 : 1) : 0;
    endfunction

    // Net contribution of one store vector: each live channel votes +1 for a 0 bit, -1 for a 1 bit.
    function automatic longint contrib(input logic [63:0] st, input logic [63:0] cr, input int n);
        longint s = 0;
        for (int k = 0; k < n; k++) begin
            if (st[k]) s += cr[k] ? -1 : 1;
        end
        return s;
    endfunction

    function automatic void accum(inout longint c, inout bit s, input longint v,
                                  input int w, input bit satm);
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -(longint'(1) << (w - 1));
        longint r  = c + v;
        if (r > hi) begin
            s = 1'b1;
            r = satm ? hi : r - (longint'(1) << w);
        end else if (r < lo) begin
            s = 1'b1;
            r = satm ? lo : r + (longint'(1) << w);
        end
        c = r;
    endfunction

    function automatic void step_a();
        if (clr_a) begin
            ma_cnt = init_val(te_a, tr_a);
            ma_sat = 1'b0;
            qa.delete();
        end else begin
            while (qa.size() > 0 && qa[0].due == cyc) begin
                pend_t p = qa.pop_front();
                accum(ma_cnt, ma_sat, p.val, 30, 1'b1);
            end
            if (st_a != 0) qa.push_back('{due: cyc + C_LA + 1, val: contrib(64'(st_a), 64'(cr_a), 4)});
        end
    endfunction

    function automatic void step_b();
        if (clr_b) begin
            mb_cnt = init_val(te_b, tr_b);
            mb_sat = 1'b0;
            qb.delete();
        end else begin
            while (qb.size() > 0 && qb[0].due == cyc) begin
                pend_t p = qb.pop_front();
                accum(mb_cnt, mb_sat, p.val, 30, 1'b1);
            end
            if (st_b != 0) qb.push_back('{due: cyc + C_LB + 1, val: contrib(64'(st_b), 64'(cr_b), 32)});
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        step_a();
        step_b();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic vec_t v(input bit clr, input bit te, input bit tr, input bit [3:0] st,
                               input bit [3:0] cr, input int cnt, input bit busy);
        vec_t r;
        r.clr = clr; r.te = te; r.tr = tr; r.st = st; r.cr = cr; r.cnt = cnt; r.busy = busy;
        return r;
    endfunction

    initial begin
        tbl[0]  = v(1, 0, 0, 4'b0000, 4'b0000,  0, 0);
        tbl[1]  = v(0, 0, 0, 4'b1111, 4'b0001,  0, 1);
        tbl[2]  = v(0, 0, 0, 4'b0000, 4'b0000,  0, 1);
        tbl[3]  = v(0, 0, 0, 4'b0000, 4'b0000,  0, 1);
        tbl[4]  = v(0, 0, 0, 4'b0000, 4'b0000,  2, 0);
        tbl[5]  = v(1, 1, 0, 4'b0000, 4'b0000,  1, 0);
        tbl[6]  = v(0, 0, 0, 4'b0011, 4'b0011,  1, 1);
        tbl[7]  = v(0, 0, 0, 4'b0100, 4'b0000,  1, 1);
        tbl[8]  = v(0, 0, 0, 4'b1000, 4'b1000,  1, 1);
        tbl[9]  = v(0, 0, 0, 4'b0000, 4'b0000, -1, 1);
        tbl[10] = v(0, 0, 0, 4'b0000, 4'b0000,  0, 1);
        tbl[11] = v(0, 0, 0, 4'b0000, 4'b0000, -1, 0);
        tbl[12] = v(0, 0, 0, 4'b1111, 4'b0000, -1, 1);
        tbl[13] = v(0, 0, 0, 4'b1111, 4'b0000, -1, 1);
        tbl[14] = v(1, 1, 0, 4'b1111, 4'b0000,  1, 0);
        tbl[15] = v(0, 0, 0, 4'b0000, 4'b0000,  1, 0);
        tbl[16] = v(0, 0, 0, 4'b0000, 4'b0000,  1, 0);
        tbl[17] = v(0, 0, 0, 4'b0000, 4'b0000,  1, 0);

        #2;
        check("reset count_a", cnt_a, 0);
        check("reset busy_a", busy_a, 0);
        check("reset sat_a", sat_a, 0);
        check("reset sign_a", sign_a, 0);
        check("reset count_b", cnt_b, 0);
        check("reset count_c", cnt_c, 0);
        check("reset count_d", cnt_d, 0);
        #10;
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            clr_a = tbl[i].clr; te_a = tbl[i].te; tr_a = tbl[i].tr;
            st_a  = tbl[i].st;  cr_a = tbl[i].cr;
            tick();
            check($sformatf("vec%0d count", i), cnt_a, tbl[i].cnt);
            check($sformatf("vec%0d busy", i), busy_a, tbl[i].busy);
            check($sformatf("vec%0d sign", i), sign_a, (tbl[i].cnt < 0) ? 1 : 0);
        end
        clr_a = 1'b0; st_a = '0; cr_a = '0;

        // NCORE=32: five back-to-back full-width stores after a -1 preload.
        clr_b = 1'b1; te_b = 1'b1; tr_b = 1'b1;
        tick();
        check("b clear -1", cnt_b, -1);
        clr_b = 1'b0; te_b = 1'b0; tr_b = 1'b0;
        st_b = '1; cr_b = '0;
        idle(5);
        st_b = '0;
        tick();
        check("b before first due", cnt_b, -1);
        idle(5);
        check("b five stores", cnt_b, 159);
        check("b busy drained", busy_b, 0);

        // W=4 pair: saturating (c) and wrapping (d) from a common stream.
        clr_cd = 1'b1; te_cd = 1'b1; tr_cd = 1'b0;
        tick();
        check("cd clear +1", cnt_c, 1);
        clr_cd = 1'b0; te_cd = 1'b0;
        st_cd = 4'b1111; cr_cd = 4'b0000; tick();
        st_cd = 4'b0001; tick();
        st_cd = 4'b0000; idle(3);
        check("c reach 6", cnt_c, 6);
        check("d reach 6", cnt_d, 6);
        check("d no sat yet", sat_d, 0);
        st_cd = 4'b1111; tick();
        st_cd = 4'b0000; idle(3);
        check("c clamp 7", cnt_c, 7);
        check("c sat set", sat_c, 1);
        check("d wrap -6", cnt_d, -6);
        check("d sat set", sat_d, 1);
        check("d sign", sign_d, 1);
        st_cd = 4'b1111; idle(3);
        st_cd = 4'b0000; idle(3);
        check("c stays 7", cnt_c, 7);
        check("c sat sticky", sat_c, 1);
        check("d wraps back 6", cnt_d, 6);
        check("d sat sticky", sat_d, 1);
        clr_cd = 1'b1; tick();
        clr_cd = 1'b0;
        check("c clear count", cnt_c, 0);
        check("c clear sat", sat_c, 0);
        check("d clear sat", sat_d, 0);
        check("c clear busy", busy_c, 0);

        // Randomised run against the queue-based reference model.
        for (int n = 0; n < 300; n++) begin
            clr_a = ($urandom_range(0, 15) == 0);
            te_a  = 1'($urandom); tr_a = 1'($urandom);
            st_a  = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            cr_a  = 4'($urandom);
            clr_b = ($urandom_range(0, 15) == 0);
            te_b  = 1'($urandom); tr_b = 1'($urandom);
            st_b  = ($urandom_range(0, 3) == 0) ? 32'b0 : 32'($urandom);
            cr_b  = 32'($urandom);
            tick();
            check("rnd a count", cnt_a, ma_cnt);
            check("rnd a busy", busy_a, (qa.size() != 0) ? 1 : 0);
            check("rnd a sat", sat_a, ma_sat);
            check("rnd a sign", sign_a, (ma_cnt < 0) ? 1 : 0);
            check("rnd b count", cnt_b, mb_cnt);
            check("rnd b busy", busy_b, (qb.size() != 0) ? 1 : 0);
            check("rnd b sat", sat_b, mb_sat);
        end
        clr_a = 1'b0; clr_b = 1'b0;

        // Reset pulse between edges with contributions in flight.
        for (int n = 0; n < 3; n++) begin
            st_a = 4'b1111; cr_a = 4'($urandom);
            st_b = '1;      cr_b = 32'($urandom);
            tick();
        end
        check("pre-reset busy_a", busy_a, 1);
        #2;
        rst = 1'b0;
        st_a = '0; cr_a = '0; st_b = '0; cr_b = '0;
        #1;
        check("async rst count_a", cnt_a, 0);
        check("async rst busy_a", busy_a, 0);
        check("async rst sat_a", sat_a, 0);
        check("async rst sign_a", sign_a, 0);
        check("async rst count_b", cnt_b, 0);
        check("async rst busy_b", busy_b, 0);
        ma_cnt = 0; ma_sat = 1'b0; qa.delete();
        mb_cnt = 0; mb_sat = 1'b0; qb.delete();
        #2;
        rst = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            check("post rst count_a", cnt_a, 0);
            check("post rst busy_a", busy_a, 0);
            check("post rst count_b", cnt_b, 0);
            check("post rst busy_b", busy_b, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
